// File: rtl/demux41_pkg.sv
// Shared constants and types for the registered 1-to-4 round-robin demux.
// Optional per-channel accept counters are compiled in with DEMUX41_STATS_EN.
package demux41_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int STAT_W = 16;

  typedef enum logic {
    MODE_EXPLICIT = 1'b0,
    MODE_RR       = 1'b1
  } mode_e;

  // Per-slot control produced by the steering logic each cycle
  typedef struct packed {
    logic load;
    logic drain;
  } slot_ctl_t;

  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] p);
    return p + SEL_W'(1);
  endfunction

endpackage

// File: rtl/demux41_slot.sv
// One-entry holding register for a single demux channel.
// With DEMUX41_STATS_EN a saturating count of loaded words is kept alongside.
module demux41_slot
  import demux41_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  slot_ctl_t         ctl,
  input  logic [W-1:0]      load_data,
`ifdef DEMUX41_STATS_EN
  output logic [STAT_W-1:0] stat_cnt,
`endif
  output logic              valid,
  output logic [W-1:0]      data
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  // A load wins over a same-cycle drain so back-to-back words leave no bubble
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ctl.load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (ctl.drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

`ifdef DEMUX41_STATS_EN
  logic [STAT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (ctl.load && (cnt_q != STAT_MAX)) cnt_d = cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stat_cnt = cnt_q;
`endif

endmodule

// File: rtl/demux41_rr.sv
// Registered 1-to-4 demux: steers one valid/ready stream to four channels by
// explicit select or round-robin pointer. DEMUX41_STATS_EN adds stat_cnt.
module demux41_rr
  import demux41_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_b,
  input  logic                     auto_mode,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*W-1:0]      out_data,
`ifdef DEMUX41_STATS_EN
  output logic [NUM_CH*STAT_W-1:0] stat_cnt,
`endif
  output logic [SEL_W-1:0]         rr_ptr
);

  logic [SEL_W-1:0] rr_ptr_d, rr_ptr_q;
  logic [SEL_W-1:0] tgt;
  logic             accept;
  slot_ctl_t [NUM_CH-1:0] ctl;

  // Target is re-evaluated every cycle, so mode/select may change while stalled
  assign tgt      = (mode_e'(auto_mode) == MODE_RR) ? rr_ptr_q : in_sel;
  assign in_ready = !rst && !en_b && (!out_valid[tgt] || out_ready[tgt]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ctl[k].load  = accept && (tgt == SEL_W'(k));
      ctl[k].drain = out_valid[k] && out_ready[k];
    end
  end

  // Pointer only moves on round-robin accepts, never skipping a busy channel
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && (mode_e'(auto_mode) == MODE_RR)) rr_ptr_d = rr_next(rr_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux41_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .ctl       (ctl[k]),
      .load_data (in_data),
`ifdef DEMUX41_STATS_EN
      .stat_cnt  (stat_cnt[k*STAT_W +: STAT_W]),
`endif
      .valid     (out_valid[k]),
      .data      (out_data[k*W +: W])
    );
  end

endmodule

// File: tb/tb_demux41_rr.sv
// Directed self-checking bench for demux41_rr; stats block exercised
// only when DEMUX41_STATS_EN is defined.
module tb_demux41_rr;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst, en_b, auto_mode, in_valid, in_ready;
  logic [1:0]  in_sel, rr_ptr;
  logic [W-1:0] in_data;
  logic [3:0]  out_valid, out_ready;
  logic [4*W-1:0] out_data;
`ifdef DEMUX41_STATS_EN
  logic [63:0] stat_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux41_rr #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_b      (en_b),
    .auto_mode (auto_mode),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef DEMUX41_STATS_EN
    .stat_cnt  (stat_cnt),
`endif
    .rr_ptr    (rr_ptr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en_b = 1'b0; auto_mode = 1'b0; in_sel = 2'd0;
    in_valid = 1'b0; in_data = '0; out_ready = 4'h0;
    step(); step();
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_ptr",   64'(rr_ptr),    64'h0);
    chk("rst_data",  64'(out_data),  64'h0);
    in_valid = 1'b1;
    #1 chk("rst_ready", 64'(in_ready), 64'h0);
    in_valid = 1'b0;
    rst = 1'b0;
    step();

    // Explicit select to channel 2
    out_ready = 4'hF; auto_mode = 1'b0; in_sel = 2'd2;
    in_valid = 1'b1; in_data = 8'hA5;
    #1 chk("exp_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    chk("exp_valid", 64'(out_valid), 64'h4);
    chk("exp_data",  64'(out_data),  64'h00A5_0000);
    chk("exp_ptr",   64'(rr_ptr),    64'h0);
    step();
    chk("exp_drain", 64'(out_valid), 64'h0);

    // Round-robin, back-to-back words
    auto_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      #1 chk("rr_ready", 64'(in_ready), 64'h1);
      step();
      chk("rr_valid", 64'(out_valid), 64'(4'b0001 << (i % 4)));
      chk("rr_data",  64'(out_data[(i % 4)*W +: W]), 64'(8'h10 + i));
    end
    in_valid = 1'b0;
    chk("rr_ptr5", 64'(rr_ptr), 64'h1);
    step();

    // Stall on channel 1, then release with same-cycle drain and reload
    out_ready = 4'b1101;
    in_valid = 1'b1; in_data = 8'h21;
    step();
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h22 + i);
      step();
    end
    in_data = 8'h25;
    #1 chk("stall_ready", 64'(in_ready), 64'h0);
    chk("stall_ptr", 64'(rr_ptr), 64'h1);
    step();
    chk("stall_ptr2", 64'(rr_ptr), 64'h1);
    chk("stall_hold", 64'(out_data[15:8]), 64'h21);
    chk("stall_vld",  64'(out_valid[1]),  64'h1);
    out_ready = 4'hF;
    #1 chk("rel_ready", 64'(in_ready), 64'h1);
    step();
    chk("rel_valid", 64'(out_valid), 64'h2);
    chk("rel_data",  64'(out_data[15:8]), 64'h25);
    chk("rel_ptr",   64'(rr_ptr), 64'h2);
    in_valid = 1'b0;
    step();

    // en_b blocks accepts but slot 3 still drains
    auto_mode = 1'b0; in_sel = 2'd3; out_ready = 4'b0111;
    in_valid = 1'b1; in_data = 8'h3C;
    step();
    chk("enb_load", 64'(out_valid), 64'h8);
    chk("enb_ptr0", 64'(rr_ptr), 64'h2);
    en_b = 1'b1; auto_mode = 1'b1; out_ready = 4'hF; in_data = 8'h77;
    #1 chk("enb_ready", 64'(in_ready), 64'h0);
    chk("enb_data", 64'(out_data[31:24]), 64'h3C);
    step();
    chk("enb_drain", 64'(out_valid), 64'h0);
    chk("enb_ptr",   64'(rr_ptr), 64'h2);
    en_b = 1'b0; in_valid = 1'b0;

    // Reset with all four slots occupied
    auto_mode = 1'b0; out_ready = 4'h0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i); in_data = 8'(8'h40 + i);
      step();
    end
    in_valid = 1'b0;
    chk("full_valid", 64'(out_valid), 64'hF);
    chk("full_data",  64'(out_data),  64'h4342_4140);
    rst = 1'b1;
    step();
    chk("mrst_valid", 64'(out_valid), 64'h0);
    chk("mrst_ptr",   64'(rr_ptr),    64'h0);
    chk("mrst_data",  64'(out_data),  64'h0);
    rst = 1'b0;
    step();
    chk("post_valid", 64'(out_valid), 64'h0);

`ifdef DEMUX41_STATS_EN
    chk("stat_zero", stat_cnt, 64'h0);
    out_ready = 4'hF; in_sel = 2'd0; in_valid = 1'b1; in_data = 8'h01;
    for (int i = 0; i < 70000; i++) step();
    in_valid = 1'b0;
    chk("stat_sat", stat_cnt, 64'h0000_0000_0000_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
